cc_lives_manager: RTL and testbench
===================================

CC_LIVES_MANAGER -- requirements
Module: cc_lives_manager

Interface
REQ-001 The block SHALL have parameter LIVES_DATAWIDTH, default 3, meaning the width of the lives counter.
REQ-002 The block SHALL have parameter LIVES_INIT, default 3, meaning the lives loaded at reset and restart.
REQ-003 The block SHALL have parameter LIVES_MAX, default 7, meaning the saturation ceiling for bonus increments.
REQ-004 The block SHALL have parameter LIVES_LOW_THRESHOLD, default 1, meaning the low flag asserts when lives < threshold.
REQ-005 The block SHALL have parameter INVULN_DATAWIDTH, default 4, meaning the invulnerability timer width.
REQ-006 The block SHALL have parameter INVULN_CYCLES, default 4, meaning the invulnerability window length in cycles (1..2^INVULN_DATAWIDTH-1).
REQ-007 The block SHALL have port CC_LIVES_MANAGER_CLOCK_50, input, 1 bit, the single clock, with all logic on its rising edge.
REQ-008 The block SHALL have port CC_LIVES_MANAGER_RESET_InHigh, input, 1 bit, a synchronous, active-high reset.
REQ-009 The block SHALL have port CC_LIVES_MANAGER_hit_InHigh, input, 1 bit, a one-cycle collision pulse.
REQ-010 The block SHALL have port CC_LIVES_MANAGER_bonus_InHigh, input, 1 bit, a one-cycle extra-life pulse.
REQ-011 The block SHALL have port CC_LIVES_MANAGER_restart_InHigh, input, 1 bit, a one-cycle new-game request.
REQ-012 The block SHALL have port CC_LIVES_MANAGER_lives_Out, output, LIVES_DATAWIDTH bits, the registered lives count.
REQ-013 The block SHALL have port CC_LIVES_MANAGER_low_OutHigh, output, 1 bit, asserted while lives_Out < LIVES_LOW_THRESHOLD.
REQ-014 The block SHALL have port CC_LIVES_MANAGER_invuln_OutHigh, output, 1 bit, asserted while state is INVULN.
REQ-015 The block SHALL have port CC_LIVES_MANAGER_gameover_OutHigh, output, 1 bit, asserted while state is GAMEOVER.
REQ-016 The block SHALL have port CC_LIVES_MANAGER_lifelost_OutHigh, output, 1 bit, a registered one-cycle pulse in the cycle after each accepted hit.

Function
REQ-017 The FSM SHALL have states PLAY, INVULN and GAMEOVER.
REQ-018 In PLAY, a hit with lives > 1 SHALL decrement lives, load the timer with INVULN_CYCLES-1 and go to INVULN; the update is visible on the next cycle.
REQ-019 In PLAY, a hit with lives == 1 SHALL set lives to 0 and go directly to GAMEOVER, with no INVULN.
REQ-020 In INVULN, the timer SHALL decrement each cycle and the FSM SHALL return to PLAY when the timer equals 0, so invuln_OutHigh is high for exactly INVULN_CYCLES cycles.
REQ-021 In INVULN, hits SHALL be ignored, with no decrement and no lifelost pulse.
REQ-022 A bonus in PLAY or INVULN SHALL increment lives, saturating at LIVES_MAX; at LIVES_MAX it has no effect.
REQ-023 Simultaneous hit and bonus in PLAY SHALL apply the hit only, and the bonus is dropped.
REQ-024 In GAMEOVER, hit and bonus SHALL be ignored, and lives stays 0.
REQ-025 Restart in any state SHALL load LIVES_INIT, clear the timer and go to PLAY next cycle; restart overrides a same-cycle hit or bonus.
REQ-026 low_OutHigh SHALL be combinational from the registered count, with no extra latency.
REQ-027 Counter arithmetic SHALL never wrap: there is no decrement below 0 and no increment above LIVES_MAX.
REQ-028 The block SHALL require 1 <= LIVES_INIT <= LIVES_MAX <= 2^LIVES_DATAWIDTH-1; other values are unsupported.

Reset
REQ-029 Reset SHALL set state to PLAY, lives_Out to LIVES_INIT, the timer to 0, and invuln/gameover/lifelost to 0.
REQ-030 low_OutHigh after reset SHALL follow LIVES_INIT (0 with defaults).
REQ-031 Reset SHALL take priority over restart, hit and bonus, and a reset mid-INVULN SHALL abort the window immediately.

Configuration
REQ-032 Macro CC_LIVES_MANAGER_BONUS_EN defined SHALL enable bonus handling per REQ-022/REQ-023.
REQ-033 Without CC_LIVES_MANAGER_BONUS_EN, bonus_InHigh SHALL be ignored in all states and lives never increases except via reset or restart; the port remains present.

Verification
REQ-034 The bench SHALL check: reset released, defaults -> lives=3, low=0, invuln=0, gameover=0.
REQ-035 The bench SHALL check: hit pulse in PLAY with lives=3 -> next cycle lives=2, lifelost=1 for one cycle, invuln=1 for exactly 4 cycles, then PLAY.
REQ-036 The bench SHALL check: hit during INVULN (2nd cycle of window) -> lives unchanged at 2, no lifelost, window not extended.
REQ-037 The bench SHALL check: three hits spaced 6 cycles from lives=3 -> lives 2,1,0; last hit gives gameover=1, low=1, invuln stays 0; further hits/bonus leave lives=0.
REQ-038 The bench SHALL check: with BONUS_EN, lives=7 plus bonus -> stays 7; lives=2 with hit and bonus in the same cycle -> lives=1; without BONUS_EN, bonus from lives=3 -> lives=3.
REQ-039 The bench SHALL check: restart in GAMEOVER, or restart asserted with a simultaneous hit -> next cycle lives=3, gameover=0, invuln=0, state PLAY.

Source files
------------

// File: rtl/cc_lives_manager.sv
// Lives counter with a post-hit invulnerability window and a game-over state.
// Optional feature: define CC_LIVES_MANAGER_BONUS_EN to let bonus pulses add
// lives (saturating at LIVES_MAX). Without it, bonus_InHigh is ignored.
// Supported parameters: 1 <= LIVES_INIT <= LIVES_MAX <= 2^LIVES_DATAWIDTH-1,
// 1 <= INVULN_CYCLES <= 2^INVULN_DATAWIDTH-1.
module cc_lives_manager #(
    parameter int unsigned LIVES_DATAWIDTH     = 3,
    parameter int unsigned LIVES_INIT          = 3,
    parameter int unsigned LIVES_MAX           = 7,
    parameter int unsigned LIVES_LOW_THRESHOLD = 1,
    parameter int unsigned INVULN_DATAWIDTH    = 4,
    parameter int unsigned INVULN_CYCLES       = 4
) (
    input  logic                       CC_LIVES_MANAGER_CLOCK_50,
    input  logic                       CC_LIVES_MANAGER_RESET_InHigh,
    input  logic                       CC_LIVES_MANAGER_hit_InHigh,
    input  logic                       CC_LIVES_MANAGER_bonus_InHigh,
    input  logic                       CC_LIVES_MANAGER_restart_InHigh,
    output logic [LIVES_DATAWIDTH-1:0] CC_LIVES_MANAGER_lives_Out,
    output logic                       CC_LIVES_MANAGER_low_OutHigh,
    output logic                       CC_LIVES_MANAGER_invuln_OutHigh,
    output logic                       CC_LIVES_MANAGER_gameover_OutHigh,
    output logic                       CC_LIVES_MANAGER_lifelost_OutHigh
);

    localparam logic [LIVES_DATAWIDTH-1:0]  LIVES_INIT_W = LIVES_DATAWIDTH'(LIVES_INIT);
    localparam logic [LIVES_DATAWIDTH-1:0]  LIVES_MAX_W  = LIVES_DATAWIDTH'(LIVES_MAX);
    localparam logic [LIVES_DATAWIDTH-1:0]  LIVES_ONE    = LIVES_DATAWIDTH'(1);
    localparam logic [LIVES_DATAWIDTH-1:0]  LIVES_ZERO   = '0;
    // One extra bit so a threshold of 2^LIVES_DATAWIDTH still compares correctly.
    localparam logic [LIVES_DATAWIDTH:0]    LOW_TH_W     = (LIVES_DATAWIDTH + 1)'(LIVES_LOW_THRESHOLD);
    localparam logic [INVULN_DATAWIDTH-1:0] TIMER_LOAD   = INVULN_DATAWIDTH'(INVULN_CYCLES - 1);
    localparam logic [INVULN_DATAWIDTH-1:0] TIMER_ONE    = INVULN_DATAWIDTH'(1);
    localparam logic [INVULN_DATAWIDTH-1:0] TIMER_ZERO   = '0;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        INVULN   = 2'd1,
        GAMEOVER = 2'd2
    } stateT;

    stateT                       stateReg;
    stateT                       stateNext;
    logic [LIVES_DATAWIDTH-1:0]  livesNext;
    logic [INVULN_DATAWIDTH-1:0] timerReg;
    logic [INVULN_DATAWIDTH-1:0] timerNext;
    logic                        lifelostNext;
    logic                        bonusAccept;

`ifdef CC_LIVES_MANAGER_BONUS_EN
    // A bonus only counts while below the ceiling, so the count never wraps.
    assign bonusAccept = CC_LIVES_MANAGER_bonus_InHigh &&
                         (CC_LIVES_MANAGER_lives_Out != LIVES_MAX_W);
`else
    // Bonus handling compiled out; the port stays for a stable interface.
    logic unusedBonus;
    assign unusedBonus = CC_LIVES_MANAGER_bonus_InHigh;
    assign bonusAccept = 1'b0;
`endif

    // Low-lives flag decoded straight from the registered count.
    assign CC_LIVES_MANAGER_low_OutHigh = ({1'b0, CC_LIVES_MANAGER_lives_Out} < LOW_TH_W);

    // Next-state, next-count, timer and life-lost pulse.
    always_comb begin
        stateNext    = stateReg;
        livesNext    = CC_LIVES_MANAGER_lives_Out;
        timerNext    = timerReg;
        lifelostNext = 1'b0;

        if (CC_LIVES_MANAGER_restart_InHigh) begin
            stateNext = PLAY;
            livesNext = LIVES_INIT_W;
            timerNext = TIMER_ZERO;
        end else begin
            case (stateReg)
                PLAY: begin
                    if (CC_LIVES_MANAGER_hit_InHigh) begin
                        // A hit wins over a same-cycle bonus.
                        if (CC_LIVES_MANAGER_lives_Out > LIVES_ONE) begin
                            livesNext    = CC_LIVES_MANAGER_lives_Out - LIVES_ONE;
                            timerNext    = TIMER_LOAD;
                            stateNext    = INVULN;
                            lifelostNext = 1'b1;
                        end else if (CC_LIVES_MANAGER_lives_Out == LIVES_ONE) begin
                            livesNext    = LIVES_ZERO;
                            stateNext    = GAMEOVER;
                            lifelostNext = 1'b1;
                        end else begin
                            // Zero lives in PLAY is unreachable; fall into game over safely.
                            stateNext = GAMEOVER;
                        end
                    end else if (bonusAccept) begin
                        livesNext = CC_LIVES_MANAGER_lives_Out + LIVES_ONE;
                    end
                end
                INVULN: begin
                    // Hits are ignored for the whole window.
                    if (timerReg == TIMER_ZERO) begin
                        stateNext = PLAY;
                    end else begin
                        timerNext = timerReg - TIMER_ONE;
                    end
                    if (bonusAccept) begin
                        livesNext = CC_LIVES_MANAGER_lives_Out + LIVES_ONE;
                    end
                end
                GAMEOVER: begin
                    livesNext = LIVES_ZERO;
                end
                default: begin
                    stateNext = PLAY;
                    livesNext = LIVES_INIT_W;
                    timerNext = TIMER_ZERO;
                end
            endcase
        end
    end

    // State and output registers; reset outranks every other input.
    always_ff @(posedge CC_LIVES_MANAGER_CLOCK_50) begin
        if (CC_LIVES_MANAGER_RESET_InHigh) begin
            stateReg                          <= PLAY;
            timerReg                          <= TIMER_ZERO;
            CC_LIVES_MANAGER_lives_Out        <= LIVES_INIT_W;
            CC_LIVES_MANAGER_invuln_OutHigh   <= 1'b0;
            CC_LIVES_MANAGER_gameover_OutHigh <= 1'b0;
            CC_LIVES_MANAGER_lifelost_OutHigh <= 1'b0;
        end else begin
            stateReg                          <= stateNext;
            timerReg                          <= timerNext;
            CC_LIVES_MANAGER_lives_Out        <= livesNext;
            CC_LIVES_MANAGER_invuln_OutHigh   <= (stateNext == INVULN);
            CC_LIVES_MANAGER_gameover_OutHigh <= (stateNext == GAMEOVER);
            CC_LIVES_MANAGER_lifelost_OutHigh <= lifelostNext;
        end
    end

endmodule

// File: tb/tb_cc_lives_manager.sv
// Directed bench for cc_lives_manager with default parameters.
// Bonus expectations follow CC_LIVES_MANAGER_BONUS_EN as compiled.
module tb_cc_lives_manager;

    logic       clk;
    logic       rst;
    logic       hit;
    logic       bonus;
    logic       restart;
    logic [2:0] lives;
    logic       low;
    logic       invuln;
    logic       gameover;
    logic       lifelost;

    int total = 0;
    int bad   = 0;

    cc_lives_manager dut (
        .CC_LIVES_MANAGER_CLOCK_50         (clk),
        .CC_LIVES_MANAGER_RESET_InHigh     (rst),
        .CC_LIVES_MANAGER_hit_InHigh       (hit),
        .CC_LIVES_MANAGER_bonus_InHigh     (bonus),
        .CC_LIVES_MANAGER_restart_InHigh   (restart),
        .CC_LIVES_MANAGER_lives_Out        (lives),
        .CC_LIVES_MANAGER_low_OutHigh      (low),
        .CC_LIVES_MANAGER_invuln_OutHigh   (invuln),
        .CC_LIVES_MANAGER_gameover_OutHigh (gameover),
        .CC_LIVES_MANAGER_lifelost_OutHigh (lifelost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic h, input logic b, input logic r);
        hit = h; bonus = b; restart = r;
        tick();
        hit = 1'b0; bonus = 1'b0; restart = 1'b0;
    endtask

    // Hit from PLAY at lives=3, then watch the window; optionally re-hit at window cycle injectK.
    task automatic hitWindow(input string tag, input int injectK);
        pulse(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            check({tag, "_lives"},    32'(lives),    32'd2);
            check({tag, "_invuln"},   32'(invuln),   (k <= 4) ? 32'd1 : 32'd0);
            check({tag, "_lifelost"}, 32'(lifelost), (k == 1) ? 32'd1 : 32'd0);
            hit = (k == injectK);
            tick();
            hit = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; hit = 1'b0; bonus = 1'b0; restart = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_lives",    32'(lives),    32'd3);
        check("rst_low",      32'(low),      32'd0);
        check("rst_invuln",   32'(invuln),   32'd0);
        check("rst_gameover", 32'(gameover), 32'd0);
        check("rst_lifelost", 32'(lifelost), 32'd0);

        // Plain hit: window of exactly 4 cycles.
        hitWindow("hitA", 0);

        // Hit inside the window (2nd cycle) is ignored and does not extend it.
        pulse(1'b0, 1'b0, 1'b1);
        check("rsB_lives", 32'(lives), 32'd3);
        hitWindow("hitB", 2);

        // Three hits spaced 6 cycles apart run lives to zero.
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        check("h1_lives", 32'(lives), 32'd2);
        for (int i = 0; i < 5; i++) tick();
        check("h1_play", 32'(invuln), 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        check("h2_lives",    32'(lives),    32'd1);
        check("h2_lifelost", 32'(lifelost), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("h2_low", 32'(low), 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        check("h3_lives",    32'(lives),    32'd0);
        check("h3_gameover", 32'(gameover), 32'd1);
        check("h3_low",      32'(low),      32'd1);
        check("h3_invuln",   32'(invuln),   32'd0);
        check("h3_lifelost", 32'(lifelost), 32'd1);
        tick();
        check("go_invuln",   32'(invuln),   32'd0);
        check("go_lifelost", 32'(lifelost), 32'd0);
        pulse(1'b1, 1'b1, 1'b0);
        check("go_hb_lives",    32'(lives),    32'd0);
        check("go_hb_gameover", 32'(gameover), 32'd1);
        check("go_hb_lifelost", 32'(lifelost), 32'd0);

        // Restart out of game over.
        pulse(1'b0, 1'b0, 1'b1);
        check("rsGo_lives",    32'(lives),    32'd3);
        check("rsGo_gameover", 32'(gameover), 32'd0);
        check("rsGo_invuln",   32'(invuln),   32'd0);
        check("rsGo_low",      32'(low),      32'd0);

        // Restart beats a same-cycle hit; next hit proves we are in PLAY.
        pulse(1'b1, 1'b0, 1'b1);
        check("rsHit_lives",    32'(lives),    32'd3);
        check("rsHit_invuln",   32'(invuln),   32'd0);
        check("rsHit_lifelost", 32'(lifelost), 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        check("rsHit_play_lives",  32'(lives),  32'd2);
        check("rsHit_play_invuln", 32'(invuln), 32'd1);

        // Reset in the middle of the window aborts it.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstMid_lives",  32'(lives),  32'd3);
        check("rstMid_invuln", 32'(invuln), 32'd0);

`ifdef CC_LIVES_MANAGER_BONUS_EN
        // Bonus climbs to the ceiling and saturates.
        for (int i = 4; i <= 7; i++) begin
            pulse(1'b0, 1'b1, 1'b0);
            check("bon_up", 32'(lives), 32'(i));
        end
        pulse(1'b0, 1'b1, 1'b0);
        check("bon_sat", 32'(lives), 32'd7);
        // At lives=2 a simultaneous hit and bonus applies the hit only.
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        check("bon_pre", 32'(lives), 32'd2);
        for (int i = 0; i < 4; i++) tick();
        check("bon_play", 32'(invuln), 32'd0);
        pulse(1'b1, 1'b1, 1'b0);
        check("bon_hb_lives",  32'(lives),  32'd1);
        check("bon_hb_invuln", 32'(invuln), 32'd1);
        // Bonus during the window still counts.
        pulse(1'b0, 1'b1, 1'b0);
        check("bon_inv_lives", 32'(lives), 32'd2);
`else
        // Bonus has no effect in PLAY or INVULN.
        pulse(1'b0, 1'b1, 1'b0);
        check("nobon_play", 32'(lives), 32'd3);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        check("nobon_inv",  32'(lives), 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
